// File: rtl/coin_acceptor.sv
// Coin acceptor front end: collects 1/3/5-unit coins against a latched cost,
// hands a cost/paid (or refund) request to the change machine, and owns the hopper inventory.
module coin_acceptor #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned INIT_COUNT     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] cost_i,
  input  logic       coin_valid_i,
  input  logic [2:0] coin_type_i,
  input  logic       cancel_i,
  output logic       coin_reject_o,
  output logic [3:0] paid_o,
  output logic       busy_o,
  output logic       req_valid_o,
  input  logic       req_ready_i,
  output logic [3:0] req_cost_o,
  output logic [3:0] req_paid_o,
  output logic       req_refund_o,
  input  logic       disp_valid_i,
  input  logic [2:0] disp_first_i,
  input  logic [2:0] disp_second_i,
  output logic [1:0] pentagons_o,
  output logic [1:0] triangles_o,
  output logic [1:0] circles_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, REQUEST} state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CNT_INIT   = 2'(INIT_COUNT);
  localparam logic [1:0] NO_COIN    = 2'd3;

  state_e          state_q, state_d;
  logic [3:0]      cost_q, cost_d;
  logic [3:0]      paid_q, paid_d;
  logic [7:0]      timer_q, timer_d;
  logic            refund_q, refund_d;
  logic            coin_reject_q, coin_reject_d;
  // Hopper counts indexed 0 = circles (1), 1 = triangles (3), 2 = pentagons (5).
  logic [2:0][1:0] cnt_q, cnt_d;

  function automatic logic [1:0] code_to_idx(input logic [2:0] code);
    case (code)
      3'd1:    return 2'd0;
      3'd3:    return 2'd1;
      3'd5:    return 2'd2;
      default: return NO_COIN;
    endcase
  endfunction

  logic [1:0] coin_idx;
  logic       coin_room;
  logic [4:0] paid_sum;
  logic       coin_accept;

  always_comb begin
    coin_idx = code_to_idx(coin_type_i);
    case (coin_idx)
      2'd0:    coin_room = (cnt_q[0] != 2'd3);
      2'd1:    coin_room = (cnt_q[1] != 2'd3);
      2'd2:    coin_room = (cnt_q[2] != 2'd3);
      default: coin_room = 1'b0;
    endcase
    // Five-bit sum so an overpaying coin is refused instead of wrapping paid.
    paid_sum    = {1'b0, paid_q} + {2'b00, coin_type_i};
    coin_accept = (state_q == COLLECT) && coin_valid_i && !cancel_i &&
                  coin_room && (paid_sum <= 5'd15);
    coin_reject_d = coin_valid_i && !coin_accept;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    cnt_d = cnt_q;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] sum;
      logic [2:0] dec;
      logic [2:0] diff;
      sum = {1'b0, cnt_q[k]} + ((coin_accept && coin_idx == 2'(k)) ? 3'd1 : 3'd0);
      dec = 3'd0;
      if (disp_valid_i) begin
        if (code_to_idx(disp_first_i) == 2'(k))  dec = dec + 3'd1;
        if (code_to_idx(disp_second_i) == 2'(k)) dec = dec + 3'd1;
      end
      diff = sum - dec;
      if (sum <= dec)        cnt_d[k] = 2'd0;
      else if (diff > 3'd3)  cnt_d[k] = 2'd3;
      else                   cnt_d[k] = diff[1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    paid_d   = paid_q;
    timer_d  = timer_q;
    refund_d = refund_q;
    case (state_q)
      IDLE: begin
        if (start_i && cost_i != 4'd0) begin
          cost_d  = cost_i;
          paid_d  = 4'd0;
          timer_d = 8'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (coin_accept) begin
          paid_d  = paid_sum[3:0];
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
        if (cancel_i) begin
          state_d  = REQUEST;
          refund_d = 1'b1;
        end else if (coin_accept && paid_sum >= {1'b0, cost_q}) begin
          state_d  = REQUEST;
          refund_d = 1'b0;
        end else if (!coin_accept && timer_q == TIMER_LAST) begin
          state_d  = REQUEST;
          refund_d = 1'b1;
        end
      end
      REQUEST: begin
        if (req_ready_i) begin
          paid_d   = 4'd0;
          refund_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cost_q        <= 4'd0;
      paid_q        <= 4'd0;
      timer_q       <= 8'd0;
      refund_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      cnt_q         <= {3{CNT_INIT}};
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values of the others.
      state_q       <= state_d;
      cost_q        <= cost_d;
      paid_q        <= paid_d;
      timer_q       <= timer_d;
      refund_q      <= refund_d;
      coin_reject_q <= coin_reject_d;
      cnt_q         <= cnt_d;
    end
  end

  assign coin_reject_o = coin_reject_q;
  assign paid_o        = paid_q;
  assign busy_o        = (state_q != IDLE);
  assign req_valid_o   = (state_q == REQUEST);
  assign req_cost_o    = (req_valid_o && !refund_q) ? cost_q : 4'd0;
  assign req_paid_o    = req_valid_o ? paid_q : 4'd0;
  assign req_refund_o  = refund_q;
  assign circles_o     = cnt_q[0];
  assign triangles_o   = cnt_q[1];
  assign pentagons_o   = cnt_q[2];

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios then random traffic,
// all compared every cycle against a transaction-level model of the acceptor.
module tb_coin_acceptor;

  localparam int TMO  = 4;
  localparam int INIT = 2;

  logic       clk, rst;
  logic       start, coin_valid, cancel, req_ready, disp_valid;
  logic [3:0] cost;
  logic [2:0] coin_type, disp_first, disp_second;
  logic       coin_reject, busy, req_valid, req_refund;
  logic [3:0] paid, req_cost, req_paid;
  logic [1:0] pentagons, triangles, circles;

  coin_acceptor #(.TIMEOUT_CYCLES(TMO), .INIT_COUNT(INIT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cost_i(cost),
    .coin_valid_i(coin_valid), .coin_type_i(coin_type), .cancel_i(cancel),
    .coin_reject_o(coin_reject), .paid_o(paid), .busy_o(busy),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_cost_o(req_cost),
    .req_paid_o(req_paid), .req_refund_o(req_refund), .disp_valid_i(disp_valid),
    .disp_first_i(disp_first), .disp_second_i(disp_second),
    .pentagons_o(pentagons), .triangles_o(triangles), .circles_o(circles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: phase 0 waiting, 1 collecting coins, 2 request outstanding.
  int m_phase, m_cost, m_paid, m_idle, m_refund, m_rej;
  int m_cnt[3];   // circles, triangles, pentagons

  function automatic int kind_of(input int code);
    case (code)
      1: return 0;
      3: return 1;
      5: return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cost = 0; m_paid = 0; m_idle = 0; m_refund = 0; m_rej = 0;
    for (int k = 0; k < 3; k++) m_cnt[k] = INIT;
  endtask

  task automatic model_step();
    int kind, acc, delta;
    kind = kind_of(int'(coin_type));
    acc  = 0;
    if (m_phase == 1 && coin_valid && !cancel && kind >= 0)
      if (m_cnt[kind] < 3 && m_paid + int'(coin_type) <= 15) acc = 1;
    m_rej = (coin_valid && acc == 0) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      delta = (acc == 1 && kind == k) ? 1 : 0;
      if (disp_valid) begin
        if (kind_of(int'(disp_first)) == k)  delta--;
        if (kind_of(int'(disp_second)) == k) delta--;
      end
      m_cnt[k] = m_cnt[k] + delta;
      if (m_cnt[k] < 0) m_cnt[k] = 0;
      if (m_cnt[k] > 3) m_cnt[k] = 3;
    end
    if (m_phase == 0) begin
      if (start && cost != 0) begin
        m_phase = 1; m_cost = int'(cost); m_paid = 0; m_idle = 0;
      end
    end else if (m_phase == 1) begin
      if (acc == 1) m_paid += int'(coin_type);
      m_idle = (acc == 1) ? 0 : m_idle + 1;
      if (cancel) begin
        m_phase = 2; m_refund = 1;
      end else if (acc == 1 && m_paid >= m_cost) begin
        m_phase = 2; m_refund = 0;
      end else if (m_idle == TMO) begin
        m_phase = 2; m_refund = 1;
      end
    end else if (req_ready) begin
      m_phase = 0; m_paid = 0; m_refund = 0;
    end
  endtask

  task automatic compare_all();
    check("paid", int'(paid), m_paid);
    check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    check("req_valid", int'(req_valid), (m_phase == 2) ? 1 : 0);
    check("req_cost", int'(req_cost), (m_phase == 2 && m_refund == 0) ? m_cost : 0);
    check("req_paid", int'(req_paid), (m_phase == 2) ? m_paid : 0);
    check("req_refund", int'(req_refund), m_refund);
    check("coin_reject", int'(coin_reject), m_rej);
    check("circles", int'(circles), m_cnt[0]);
    check("triangles", int'(triangles), m_cnt[1]);
    check("pentagons", int'(pentagons), m_cnt[2]);
  endtask

  task automatic cyc(input logic st, input logic [3:0] cs, input logic cv,
                     input logic [2:0] ct, input logic cn, input logic rd,
                     input logic dv, input logic [2:0] d1, input logic [2:0] d2);
    @(negedge clk);
    start = st; cost = cs; coin_valid = cv; coin_type = ct; cancel = cn;
    req_ready = rd; disp_valid = dv; disp_first = d1; disp_second = d2;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic tick();                     cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_start(input logic [3:0] c); cyc(1, c, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic coin(input logic [2:0] t);  cyc(0, 0, 1, t, 0, 0, 0, 0, 0); endtask
  task automatic ready();                    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic disp(input logic [2:0] a, input logic [2:0] b); cyc(0, 0, 0, 0, 0, 0, 1, a, b); endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_paid"}, int'(paid), 0);
    check({pfx, "_req_valid"}, int'(req_valid), 0);
    check({pfx, "_req_cost"}, int'(req_cost), 0);
    check({pfx, "_req_paid"}, int'(req_paid), 0);
    check({pfx, "_req_refund"}, int'(req_refund), 0);
    check({pfx, "_coin_reject"}, int'(coin_reject), 0);
    check({pfx, "_circles"}, int'(circles), INIT);
    check({pfx, "_triangles"}, int'(triangles), INIT);
    check({pfx, "_pentagons"}, int'(pentagons), INIT);
  endtask

  initial begin
    start = 0; cost = 0; coin_valid = 0; coin_type = 0; cancel = 0;
    req_ready = 0; disp_valid = 0; disp_first = 0; disp_second = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst = 0;

    // Normal purchase with a stalled handshake.
    do_start(7);
    check("np_busy", int'(busy), 1);
    coin(5);
    coin(3);
    check("np_paid", int'(paid), 8);
    check("np_req_cost", int'(req_cost), 7);
    check("np_pent", int'(pentagons), 3);
    check("np_tri", int'(triangles), 3);
    tick();
    tick();
    check("np_stall_cost", int'(req_cost), 7);
    check("np_stall_paid", int'(req_paid), 8);
    ready();
    check("np_done_busy", int'(busy), 0);
    check("np_done_paid", int'(paid), 0);

    // Illegal code and full pentagon hopper.
    do_start(15);
    coin(2);
    check("ill_reject", int'(coin_reject), 1);
    tick();
    check("ill_reject_pulse", int'(coin_reject), 0);
    coin(5);
    check("full_reject", int'(coin_reject), 1);
    check("full_pent", int'(pentagons), 3);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    ready();

    // Drain hoppers, then overflow boundary.
    disp(5, 5);
    disp(3, 3);
    disp(1, 1);
    check("drain_pent", int'(pentagons), 1);
    do_start(15);
    coin(5);
    coin(5);
    coin(3);
    check("ovf_paid13", int'(paid), 13);
    coin(3);
    check("ovf_reject", int'(coin_reject), 1);
    check("ovf_paid_hold", int'(paid), 13);
    coin(1);
    coin(1);
    check("ovf_paid15", int'(paid), 15);
    check("ovf_req_valid", int'(req_valid), 1);
    ready();

    // Cancel wins over a simultaneous coin.
    disp(1, 0);
    do_start(9);
    coin(3);
    coin(1);
    cyc(0, 0, 1, 1, 1, 0, 0, 0, 0);
    check("cxl_reject", int'(coin_reject), 1);
    check("cxl_refund", int'(req_refund), 1);
    check("cxl_req_paid", int'(req_paid), 4);
    check("cxl_circles", int'(circles), 2);
    tick();
    ready();

    // Timeout after exactly TMO idle COLLECT cycles.
    do_start(9);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_early", int'(req_valid), 0);
    tick();
    check("tmo_fire", int'(req_valid), 1);
    check("tmo_refund", int'(req_refund), 1);
    ready();

    // Accepted coin on cycle 3 restarts the timer.
    do_start(9);
    tick();
    tick();
    coin(1);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmr_restart_early", int'(req_valid), 0);
    tick();
    check("tmr_restart_fire", int'(req_valid), 1);
    ready();

    // Accept and double dispense on the same count in one cycle.
    disp(3, 3);
    check("col_tri_pre", int'(triangles), 1);
    do_start(9);
    cyc(0, 0, 1, 3, 0, 0, 1, 3, 3);
    check("col_tri", int'(triangles), 0);
    check("col_paid", int'(paid), 3);

    // Asynchronous reset mid-COLLECT, observed before the next edge.
    @(negedge clk);
    start = 0; coin_valid = 0; coin_type = 0; cancel = 0; req_ready = 0;
    disp_valid = 0; disp_first = 0; disp_second = 0;
    #2 rst = 1;
    #1;
    check_reset_values("arst");
    model_reset();
    @(negedge clk);
    rst = 0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       r_st, r_cv, r_cn, r_rd, r_dv;
      logic [3:0] r_cs;
      logic [2:0] r_ct, r_d1, r_d2;
      int         pick;
      r_st = ($urandom_range(0, 9) < 3);
      r_cs = 4'($urandom_range(0, 15));
      r_cv = ($urandom_range(0, 1) == 1);
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: r_ct = 3'd1;
        3, 4:    r_ct = 3'd3;
        5, 6:    r_ct = 3'd5;
        default: r_ct = 3'($urandom_range(0, 7));
      endcase
      r_cn = ($urandom_range(0, 19) == 0);
      r_rd = ($urandom_range(0, 9) < 4);
      r_dv = ($urandom_range(0, 4) == 0);
      r_d1 = 3'($urandom_range(0, 7));
      r_d2 = 3'($urandom_range(0, 7));
      cyc(r_st, r_cs, r_cv, r_ct, r_cn, r_rd, r_dv, r_d1, r_d2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
